spi_tx_frame_buffer: RTL and testbench
======================================

// Module: spi_tx_frame_buffer
// PURPOSE
//  Downstream stage of the SPI slave. It consumes the slave's byte write/read strobes, address and data.
//  It holds a 1 KiB dual-port frame RAM plus a small register file.
//  On a host START command it streams the stored frame to the modem TX path over a valid/ready byte interface.
//  Read data for the slave's MISO path comes from RAM or registers.
// PARAMETERS
//  ADDR_W    10     byte address width, matching the SPI slave o_addr
//  RAM_TOP   1019   highest RAM byte address; 0x3FC..0x3FF are registers
// PORTS
//  i_sys_clk   in   1   system clock, the only clock
//  i_rst       in   1   synchronous reset, active-high
//  i_wr        in   1   1-cycle write strobe from the SPI slave
//  i_rd        in   1   1-cycle read strobe from the SPI slave
//  i_addr      in   10  byte address from the SPI slave
//  i_data      in   8   write data from the SPI slave
//  o_data      out  8   read data to the SPI slave i_data; registered
//  o_tx_data   out  8   frame byte to the modem
//  o_tx_valid  out  1   o_tx_data is valid
//  i_tx_ready  in   1   modem accepts the byte when valid && ready
//  o_tx_last   out  1   marks the final byte of the frame
//  o_busy      out  1   a frame is being streamed
//  o_done      out  1   1-cycle pulse after the last byte is accepted
// BEHAVIOUR
//  Reset: all outputs 0, LEN=0, STATUS=0, FSM=IDLE. RAM contents are not cleared.
//  Reset mid-frame aborts on that edge; o_tx_valid is low in the following cycle.
//  Register map:
//   0x3FC LEN_LO (R/W)
//   0x3FD LEN_HI[1:0] (R/W, bits 7:2 read 0)
//   0x3FE W: CTRL (b0 START, b1 ABORT). R: STATUS {5'b0, err, done, busy}
//   0x3FF R: sent-byte count [7:0]. Writes ignored.
//  SPI write to 0x000..RAM_TOP writes RAM port A the same cycle.
//  Writes to RAM are allowed while busy; the TX engine reads what it finds.
//  SPI read: o_data is valid 1 cycle after i_rd and held until the next i_rd.
//  If i_wr and i_rd are both high, the write wins and the read is ignored.
//  LEN writes while busy are ignored.
//  START handling:
//   - START while busy is ignored.
//   - START with LEN==0 or LEN>RAM_TOP+1 sets err, stays IDLE.
//   - A valid START clears err and done.
//  ABORT while busy: FSM returns to IDLE next cycle and o_tx_valid drops without a handshake. No o_done.
//  ABORT while idle has no effect.
//  FSM states:
//   - IDLE: on valid START, ptr=0, go to FETCH.
//   - FETCH: issue port-B read at ptr, go to LOAD.
//   - LOAD: capture RAM q into o_tx_data, assert o_tx_valid, go to SEND.
//   - SEND: hold data/valid until i_tx_ready. On handshake:
//     - ptr==LEN-1: go to IDLE, pulse o_done, set done.
//     - otherwise: ptr++, go to FETCH.
//  Throughput is 1 byte per 3 cycles minimum. o_tx_data is stable while valid && !ready.
//  o_tx_last=1 only with the final byte's valid. o_busy=1 in every state except IDLE.
//  Widths: ptr and count are 11-bit, so LEN up to 1020 has no wrap.
// CONFIGURATION
//  TX_CRC_EN defined:
//   - After the payload, send 2 extra bytes of CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, high byte first.
//   - The CRC is computed over the payload bytes as they are handshaken.
//   - o_tx_last moves to the CRC low byte. The count includes the CRC bytes.
//  TX_CRC_EN undefined: no CRC logic; the frame is exactly LEN bytes.
// STRUCTURE
//  Shared header modem_defs.vh holds register addresses (REG_LEN_LO..REG_CNT), CTRL/STATUS bit indices and FSM state encodings.
//  Sub-modules:
//   - spi_tx_frame_ram: 1024x8, true dual port, synchronous read, 1-cycle latency.
//   - crc16_ccitt_byte: combinational byte update, instantiated only under TX_CRC_EN.
// TESTING
//  1. SPI write 0xA5 @0x010, then i_rd @0x010 -> o_data=0xA5 one cycle later, held.
//  2. Load 4 bytes 11,22,33,44; LEN=4; START; i_tx_ready=1 -> 4 handshakes, last on 0x44, o_done pulse, STATUS=0x02.
//  3. Same frame, ready toggling 0/1 randomly -> data stable while stalled, exact order, count=4.
//  4. START with LEN=0 and with LEN=1021 -> STATUS=0x04, no valid. Second START during busy -> ignored.
//  5. ABORT after 2 bytes of a 10-byte frame -> valid low next cycle, busy=0, no o_done, count=2.
//  6. TX_CRC_EN, payload "123456789" -> 11 bytes, trailer 0x29 then 0xB1, last on 0xB1.

Source files
------------

// File: rtl/spi_tx_frame_buffer_pkg.sv
// Shared constants for the SPI TX frame buffer: register map, CTRL/STATUS bits,
// TX engine states and CRC-16/CCITT-FALSE parameters.
package spi_tx_frame_buffer_pkg;

    localparam logic [9:0] REG_LEN_LO = 10'h3FC;
    localparam logic [9:0] REG_LEN_HI = 10'h3FD;
    localparam logic [9:0] REG_CTRL   = 10'h3FE;
    localparam logic [9:0] REG_CNT    = 10'h3FF;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND
`ifdef TX_CRC_EN
        ,
        ST_CRC_HI,
        ST_CRC_LO
`endif
    } tx_state_t;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational one-byte update of CRC-16/CCITT-FALSE, data shifted in MSB-first.
module crc16_ccitt_byte
    import spi_tx_frame_buffer_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] acc;

    always_comb begin
        acc = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            acc = acc[15] ? ((acc << 1) ^ CRC_POLY) : (acc << 1);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/spi_tx_frame_ram.sv
// 1024x8 true dual-port frame RAM, synchronous read with one cycle of latency.
// Port A read data only updates on a read, so it holds for the SPI readback path.
module spi_tx_frame_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [7:0]        b_rdata
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_addr] <= a_wdata;
            end else begin
                a_rdata <= mem[a_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/spi_tx_frame_buffer.sv
// Frame RAM + register file behind the SPI slave; streams LEN stored bytes to the modem
// on START. Define TX_CRC_EN to append a CRC-16/CCITT-FALSE trailer to every frame.
module spi_tx_frame_buffer
    import spi_tx_frame_buffer_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int RAM_TOP = 1019
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_tx_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] RAM_TOP_ADDR = ADDR_W'(RAM_TOP);
    localparam logic [10:0]       LEN_MAX      = 11'(RAM_TOP + 1);

    tx_state_t   state;
    tx_state_t   next_state;
    logic [9:0]  len;
    logic [10:0] ptr;
    logic [10:0] cnt;
    logic        err;
    logic        done_flag;
    logic        rd_from_ram;
    logic [7:0]  reg_rdata;
    logic [7:0]  reg_mux;
    logic [7:0]  status;
    logic [7:0]  ram_a_q;
    logic [7:0]  ram_b_q;
    logic        in_ram;
    logic        ctrl_wr;
    logic        start_cmd;
    logic        abort_cmd;
    logic        len_ok;
    logic        tx_hs;
    logic        is_final;
    logic        unused_cnt_hi;

    assign in_ram        = (i_addr <= RAM_TOP_ADDR);
    assign ctrl_wr       = i_wr && (i_addr == REG_CTRL);
    assign start_cmd     = ctrl_wr && i_data[CTRL_START] && (state == ST_IDLE);
    assign abort_cmd     = ctrl_wr && i_data[CTRL_ABORT] && (state != ST_IDLE);
    assign len_ok        = (len != 10'd0) && ({1'b0, len} <= LEN_MAX);
    assign tx_hs         = o_tx_valid && i_tx_ready;
    assign is_final      = ((ptr + 11'd1) == {1'b0, len});
    assign o_busy        = (state != ST_IDLE);
    assign unused_cnt_hi = ^cnt[10:8];

    spi_tx_frame_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (i_sys_clk),
        .a_en    ((i_wr || i_rd) && in_ram),
        .a_we    (i_wr),
        .a_addr  (i_addr),
        .a_wdata (i_data),
        .a_rdata (ram_a_q),
        .b_en    (state == ST_FETCH),
        .b_addr  (ptr[ADDR_W-1:0]),
        .b_rdata (ram_b_q)
    );

`ifdef TX_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_upd;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc),
        .data    (o_tx_data),
        .crc_out (crc_upd)
    );
`endif

    always_comb begin
        status            = 8'h00;
        status[STAT_BUSY] = o_busy;
        status[STAT_DONE] = done_flag;
        status[STAT_ERR]  = err;
        reg_mux           = 8'h00;
        case (i_addr)
            REG_LEN_LO: reg_mux = len[7:0];
            REG_LEN_HI: reg_mux = {6'b0, len[9:8]};
            REG_CTRL:   reg_mux = status;
            REG_CNT:    reg_mux = cnt[7:0];
            default:    reg_mux = 8'h00;
        endcase
    end

    // RAM reads return through the RAM's own output register; register reads are captured here.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            rd_from_ram <= 1'b0;
            reg_rdata   <= 8'h00;
        end else if (i_rd && !i_wr) begin
            rd_from_ram <= in_ram;
            reg_rdata   <= reg_mux;
        end
    end

    assign o_data = rd_from_ram ? ram_a_q : reg_rdata;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_cmd && len_ok) next_state = ST_FETCH;
            ST_FETCH: next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SEND;
            ST_SEND: begin
                if (tx_hs) begin
`ifdef TX_CRC_EN
                    next_state = is_final ? ST_CRC_HI : ST_FETCH;
`else
                    next_state = is_final ? ST_IDLE : ST_FETCH;
`endif
                end
            end
`ifdef TX_CRC_EN
            ST_CRC_HI: if (tx_hs) next_state = ST_CRC_LO;
            ST_CRC_LO: if (tx_hs) next_state = ST_IDLE;
`endif
            default:  next_state = ST_IDLE;
        endcase
        if (abort_cmd) begin
            next_state = ST_IDLE;
        end
    end

    // Abort drops valid immediately; a byte handshaken on that same edge still counts as sent.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            len        <= 10'd0;
            ptr        <= 11'd0;
            cnt        <= 11'd0;
            err        <= 1'b0;
            done_flag  <= 1'b0;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_done     <= 1'b0;
`ifdef TX_CRC_EN
            crc        <= CRC_INIT;
`endif
        end else begin
            o_done <= 1'b0;
            if (i_wr && (state == ST_IDLE)) begin
                if (i_addr == REG_LEN_LO) len[7:0] <= i_data;
                if (i_addr == REG_LEN_HI) len[9:8] <= i_data[1:0];
            end
            if (start_cmd) begin
                if (len_ok) begin
                    err       <= 1'b0;
                    done_flag <= 1'b0;
                    ptr       <= 11'd0;
                    cnt       <= 11'd0;
`ifdef TX_CRC_EN
                    crc       <= CRC_INIT;
`endif
                end else begin
                    err <= 1'b1;
                end
            end
            if (tx_hs) begin
                cnt <= cnt + 11'd1;
            end
            if (abort_cmd) begin
                o_tx_valid <= 1'b0;
                o_tx_last  <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        o_tx_data  <= ram_b_q;
                        o_tx_valid <= 1'b1;
`ifdef TX_CRC_EN
                        o_tx_last  <= 1'b0;
`else
                        o_tx_last  <= is_final;
`endif
                    end
                    ST_SEND: begin
                        if (tx_hs) begin
`ifdef TX_CRC_EN
                            crc <= crc_upd;
`endif
                            if (is_final) begin
`ifdef TX_CRC_EN
                                o_tx_data <= crc_upd[15:8];
`else
                                o_tx_valid <= 1'b0;
                                o_tx_last  <= 1'b0;
                                o_done     <= 1'b1;
                                done_flag  <= 1'b1;
`endif
                            end else begin
                                o_tx_valid <= 1'b0;
                                ptr        <= ptr + 11'd1;
                            end
                        end
                    end
`ifdef TX_CRC_EN
                    ST_CRC_HI: begin
                        if (tx_hs) begin
                            o_tx_data <= crc[7:0];
                            o_tx_last <= 1'b1;
                        end
                    end
                    ST_CRC_LO: begin
                        if (tx_hs) begin
                            o_tx_valid <= 1'b0;
                            o_tx_last  <= 1'b0;
                            o_done     <= 1'b1;
                            done_flag  <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_frame_buffer.sv
// Self-checking bench for spi_tx_frame_buffer: register/RAM vector table plus
// scoreboarded frame streaming, stalls, abort and START error cases.
module tb_spi_tx_frame_buffer;

    localparam logic [9:0] A_LEN_LO = 10'h3FC;
    localparam logic [9:0] A_LEN_HI = 10'h3FD;
    localparam logic [9:0] A_CTRL   = 10'h3FE;
    localparam logic [9:0] A_CNT    = 10'h3FF;
`ifdef TX_CRC_EN
    localparam int TRAILER = 2;
`else
    localparam int TRAILER = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [9:0] addr = 10'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_last;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } sb_t;

    typedef struct {
        string      name;
        logic [9:0] addr;
        logic       wr_en;
        logic [7:0] wdata;
        logic [7:0] want;
    } rw_vec_t;

    sb_t        sb[$];
    rw_vec_t    vecs[8];
    logic [7:0] payload [0:15];
    int         errors = 0;
    int         checks = 0;
    int         hs_count = 0;
    int         done_pulses = 0;
    bit         valid_seen = 0;
    bit         stall_prev = 0;
    logic [7:0] held_data = 8'h00;

    spi_tx_frame_buffer dut (
        .i_sys_clk  (clk),
        .i_rst      (rst),
        .i_wr       (wr),
        .i_rd       (rd),
        .i_addr     (addr),
        .i_data     (wdata),
        .o_data     (rdata),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_tx_last  (tx_last),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
        checks++;
        if (actual !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
        end
    endtask

    // Scoreboard side: every accepted byte is popped and compared; stalled bytes must hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid) valid_seen = 1;
            if (tx_valid && stall_prev) checkOutput("tx_data_stable", 32'(tx_data), 32'(held_data));
            if (tx_valid && tx_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got %02h, expected no byte", tx_data);
                end else begin
                    sb_t want;
                    want = sb.pop_front();
                    checkOutput("tx_data", 32'(tx_data), 32'(want.data));
                    checkOutput("tx_last", 32'(tx_last), 32'(want.last));
                end
            end
            stall_prev = tx_valid && !tx_ready;
            held_data  = tx_data;
            if (done) done_pulses++;
        end else begin
            stall_prev = 0;
        end
    end

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ payload[k][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic spi_write(input logic [9:0] a, input logic [7:0] d);
        tick();
        wr = 1'b1; addr = a; wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic spi_read(input logic [9:0] a);
        tick();
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input rw_vec_t v);
        if (v.wr_en) spi_write(v.addr, v.wdata);
        spi_read(v.addr);
    endtask

    task automatic load_frame(input int n);
        for (int k = 0; k < n; k++) spi_write(10'(k), payload[k]);
        spi_write(A_LEN_LO, 8'(n));
        spi_write(A_LEN_HI, 8'(n >> 8));
    endtask

    task automatic push_frame(input int n, input bit fixed_trailer);
        logic [15:0] c;
        for (int k = 0; k < n; k++) sb.push_back('{payload[k], (TRAILER == 0) && (k == n - 1)});
`ifdef TX_CRC_EN
        c = fixed_trailer ? 16'h29B1 : crc_model(n);
        sb.push_back('{c[15:8], 1'b0});
        sb.push_back('{c[7:0], 1'b1});
`else
        c = 16'h0000;
        if (fixed_trailer && c != 16'h0000) sb.push_back('{c[7:0], 1'b1});
`endif
    endtask

    task automatic run_frame(input int n, input bit rnd, input bit poke);
        int d0;
        int h0;
        bit finished;
        d0 = done_pulses;
        h0 = hs_count;
        finished = 0;
        spi_write(A_CTRL, 8'h01);
        @(negedge clk);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            tick();
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && cyc == 5) begin
                wr = 1'b1; addr = A_CTRL; wdata = 8'h01;
            end else if (poke && cyc == 6) begin
                wr = 1'b1; addr = A_LEN_LO; wdata = 8'h01;
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            if (done) finished = 1;
        end
        tick();
        tx_ready = 1'b0;
        wr = 1'b0;
        checkOutput("frame_finished", 32'(finished), 32'd1);
        checkOutput("done_pulses", 32'(done_pulses - d0), 32'd1);
        checkOutput("handshakes", 32'(hs_count - h0), 32'(n + TRAILER));
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        int h0;
        int local_hs;
        bit reached;
        bit got;

        vecs[0] = '{"ram_a5",       10'h010, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{"ram_base",     10'h000, 1'b1, 8'h3C, 8'h3C};
        vecs[2] = '{"ram_top",      10'h3FB, 1'b1, 8'h7E, 8'h7E};
        vecs[3] = '{"len_lo",       A_LEN_LO, 1'b1, 8'h04, 8'h04};
        vecs[4] = '{"len_hi_mask",  A_LEN_HI, 1'b1, 8'hFF, 8'h03};
        vecs[5] = '{"cnt_readonly", A_CNT,    1'b1, 8'h55, 8'h00};
        vecs[6] = '{"status_idle",  A_CTRL,   1'b0, 8'h00, 8'h00};
        vecs[7] = '{"ram_a5_again", 10'h010, 1'b0, 8'h00, 8'hA5};

        do_reset();
        @(negedge clk);
        checkOutput("rst_o_data", 32'(rdata), 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_last", 32'(tx_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, 32'(rdata), 32'(vecs[i].want));
        end

        repeat (3) @(negedge clk);
        checkOutput("o_data_held", 32'(rdata), 32'hA5);
        tick();
        wr = 1'b1; rd = 1'b1; addr = 10'h020; wdata = 8'h5A;
        tick();
        wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        checkOutput("wr_rd_read_ignored", 32'(rdata), 32'hA5);
        spi_read(10'h020);
        checkOutput("wr_rd_write_won", 32'(rdata), 32'h5A);

        $display("[TB] basic frame");
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        load_frame(4);
        push_frame(4, 1'b0);
        run_frame(4, 1'b0, 1'b0);
        spi_read(A_CTRL);
        checkOutput("status_done", 32'(rdata), 32'h02);
        spi_read(A_CNT);
        checkOutput("count_basic", 32'(rdata), 32'(4 + TRAILER));

        $display("[TB] stalled frame with START and LEN writes while busy");
        push_frame(4, 1'b0);
        run_frame(4, 1'b1, 1'b1);
        spi_read(A_CNT);
        checkOutput("count_stalled", 32'(rdata), 32'(4 + TRAILER));
        spi_read(A_LEN_LO);
        checkOutput("len_write_busy_ignored", 32'(rdata), 32'h04);

        $display("[TB] check-string frame");
        for (int k = 0; k < 9; k++) payload[k] = 8'h31 + 8'(k);
        load_frame(9);
        push_frame(9, 1'b1);
        run_frame(9, 1'b0, 1'b0);

        $display("[TB] abort mid-frame");
        for (int k = 0; k < 10; k++) payload[k] = 8'hA0 + 8'(k);
        load_frame(10);
        push_frame(10, 1'b0);
        d0 = done_pulses;
        h0 = hs_count;
        local_hs = 0;
        reached = 0;
        spi_write(A_CTRL, 8'h01);
        for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
            tick();
            tx_ready = 1'b1;
            @(negedge clk);
            if (tx_valid && tx_ready) local_hs++;
            if (local_hs >= 2) reached = 1;
        end
        tick();
        tx_ready = 1'b0;
        checkOutput("abort_two_sent", 32'(reached), 32'd1);
        got = 0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (tx_valid) got = 1;
        end
        checkOutput("abort_third_pending", 32'(got), 32'd1);
        spi_write(A_CTRL, 8'h02);
        @(negedge clk);
        checkOutput("abort_valid_low", 32'(tx_valid), 32'd0);
        checkOutput("abort_busy_low", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_pulses - d0), 32'd0);
        checkOutput("abort_handshakes", 32'(hs_count - h0), 32'd2);
        sb.delete();
        spi_read(A_CNT);
        checkOutput("abort_count", 32'(rdata), 32'd2);
        spi_read(A_CTRL);
        checkOutput("abort_status", 32'(rdata), 32'h00);

        $display("[TB] START length errors");
        do_reset();
        spi_write(A_LEN_LO, 8'h00);
        spi_write(A_LEN_HI, 8'h00);
        valid_seen = 0;
        spi_write(A_CTRL, 8'h01);
        repeat (5) @(negedge clk);
        spi_read(A_CTRL);
        checkOutput("len0_status_err", 32'(rdata), 32'h04);
        spi_write(A_LEN_LO, 8'hFD);
        spi_write(A_LEN_HI, 8'h03);
        spi_write(A_CTRL, 8'h01);
        repeat (5) @(negedge clk);
        spi_read(A_CTRL);
        checkOutput("len1021_status_err", 32'(rdata), 32'h04);
        checkOutput("err_no_valid", 32'(valid_seen), 32'd0);
        spi_write(A_LEN_LO, 8'hFC);
        spi_write(A_CTRL, 8'h01);
        @(negedge clk);
        checkOutput("len1020_busy", 32'(busy), 32'd1);
        spi_read(A_CTRL);
        checkOutput("len1020_status", 32'(rdata), 32'h01);
        spi_write(A_CTRL, 8'h02);
        @(negedge clk);
        checkOutput("len1020_abort_idle", 32'(busy), 32'd0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
